// File: rtl/free_list_if.sv
// Rename/commit-facing bundle of the physical-register free list.
// master drives requests and returns; slave is the free list itself.
interface free_list_if #(
    parameter int PREG_W = 6,
    parameter int PTR_W  = 6
);
    logic              alloc_req_i;
    logic              alloc_gnt_o;
    logic [PREG_W-1:0] alloc_preg_o;
    logic              free_valid_i;
    logic [PREG_W-1:0] free_preg_i;
    logic              ckpt_save_i;
    logic              ckpt_restore_i;
    logic              ckpt_valid_o;
    logic [PTR_W-1:0]  count_o;
    logic              empty_o;
    logic              overflow_o;

    modport master (
        output alloc_req_i, free_valid_i, free_preg_i,
        output ckpt_save_i, ckpt_restore_i,
        input  alloc_gnt_o, alloc_preg_o, ckpt_valid_o,
        input  count_o, empty_o, overflow_o
    );

    modport slave (
        input  alloc_req_i, free_valid_i, free_preg_i,
        input  ckpt_save_i, ckpt_restore_i,
        output alloc_gnt_o, alloc_preg_o, ckpt_valid_o,
        output count_o, empty_o, overflow_o
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of unmapped pregs.
// Define FREE_LIST_CKPT_EN for single-checkpoint allocation rewind.
module free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input logic       clk,
    input logic       rst,
    free_list_if.slave bus
);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] mem_q [DEPTH];
    logic [PREG_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ret;
    logic              push;
    logic              gnt;
    logic              restore;

    assign count = tail_q - head_q;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(DEPTH));
    // p0 is hardwired x0 and must never enter the list
    assign ret   = bus.free_valid_i && (bus.free_preg_i != '0);
    assign push  = ret && !full;

`ifdef FREE_LIST_CKPT_EN
    logic [PTR_W-1:0] ckpt_head_q, ckpt_head_d;
    logic             ckpt_valid_q, ckpt_valid_d;

    assign restore = bus.ckpt_restore_i;
`else
    logic unused_ckpt;

    assign restore     = 1'b0;
    assign unused_ckpt = bus.ckpt_save_i ^ bus.ckpt_restore_i;
`endif

    assign gnt = bus.alloc_req_i && !empty && !restore;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        ovf_d  = ret && full;
        if (gnt) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[tail_q[IDX_W-1:0]] = bus.free_preg_i;
            tail_d = tail_q + PTR_W'(1);
        end
`ifdef FREE_LIST_CKPT_EN
        ckpt_head_d  = ckpt_head_q;
        ckpt_valid_d = ckpt_valid_q;
        if (restore) begin
            if (ckpt_valid_q) begin
                head_d       = ckpt_head_q;
                ckpt_valid_d = 1'b0;
            end
        end else if (bus.ckpt_save_i) begin
            // snapshot is the post-edge head, so a same-cycle pop is kept
            ckpt_head_d  = head_d;
            ckpt_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_W'(NUM_AREGS + i);
            end
            head_q <= '0;
            tail_q <= PTR_W'(DEPTH);
            ovf_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef FREE_LIST_CKPT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ckpt_head_q  <= '0;
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_head_q  <= ckpt_head_d;
            ckpt_valid_q <= ckpt_valid_d;
        end
    end

    assign bus.ckpt_valid_o = ckpt_valid_q;
`else
    assign bus.ckpt_valid_o = 1'b0;
`endif

    assign bus.alloc_gnt_o  = gnt;
    assign bus.alloc_preg_o = mem_q[head_q[IDX_W-1:0]];
    assign bus.count_o      = count;
    assign bus.empty_o      = empty;
    assign bus.overflow_o   = ovf_q;
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table, directed sequences,
// and randomized traffic against a queue-based reference model.
module tb_free_list;
    localparam int DEPTH = 32;
`ifdef FREE_LIST_CKPT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    free_list_if #(.PREG_W(6), .PTR_W(6)) bus ();

    free_list dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit req;
        bit fv;
        int preg;
        int gnt;
        int ap;
        int cnt;
        int emp;
        int ovf;
        int cv;
    } vec_t;

    vec_t tv [10];

    int fq[$];
    int since[$];
    bit mv;
    bit movf;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rq, input bit fv, input int pr,
                         input bit sv, input bit rs);
        bus.alloc_req_i    = rq;
        bus.free_valid_i   = fv;
        bus.free_preg_i    = 6'(pr);
        bus.ckpt_save_i    = sv;
        bus.ckpt_restore_i = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic step(input bit rq, input bit fv, input int pr,
                        input bit sv, input bit rs, input int eg,
                        input int eap, input int ecnt, input int ecv);
        drive(rq, fv, pr, sv, rs);
        @(negedge clk);
        chk("gnt", int'(bus.alloc_gnt_o), eg);
        if (eap >= 0) chk("preg", int'(bus.alloc_preg_o), eap);
        chk("count", int'(bus.count_o), ecnt);
        chk("empty", int'(bus.empty_o), int'(ecnt == 0));
        chk("ckpt_valid", int'(bus.ckpt_valid_o), ecv);
        tick();
    endtask

    task automatic model_reset();
        fq = {};
        since = {};
        for (int i = 0; i < DEPTH; i++) fq.push_back(32 + i);
        mv = 1'b0;
        movf = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        //            req fv preg gnt ap cnt emp ovf cv
        tv[0] = '{1'b0, 1'b1, 5, 0, 32, 32, 0, 0, 0};
        tv[1] = '{1'b0, 1'b0, 0, 0, 32, 32, 0, 1, 0};
        tv[2] = '{1'b0, 1'b1, 0, 0, 32, 32, 0, 0, 0};
        tv[3] = '{1'b1, 1'b0, 0, 1, 32, 32, 0, 0, 0};
        tv[4] = '{1'b1, 1'b1, 7, 1, 33, 31, 0, 0, 0};
        tv[5] = '{1'b0, 1'b0, 0, 0, 34, 31, 0, 0, 0};
        tv[6] = '{1'b0, 1'b1, 0, 0, 34, 31, 0, 0, 0};
        tv[7] = '{1'b0, 1'b0, 0, 0, 34, 31, 0, 0, 0};
        tv[8] = '{1'b1, 1'b1, 9, 1, 34, 31, 0, 0, 0};
        tv[9] = '{1'b0, 1'b0, 0, 0, 35, 31, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].req, tv[i].fv, tv[i].preg, 0, 0);
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", i), int'(bus.alloc_gnt_o), tv[i].gnt);
            chk($sformatf("tv%0d_preg", i), int'(bus.alloc_preg_o), tv[i].ap);
            chk($sformatf("tv%0d_count", i), int'(bus.count_o), tv[i].cnt);
            chk($sformatf("tv%0d_empty", i), int'(bus.empty_o), tv[i].emp);
            chk($sformatf("tv%0d_ovf", i), int'(bus.overflow_o), tv[i].ovf);
            chk($sformatf("tv%0d_cv", i), int'(bus.ckpt_valid_o), tv[i].cv);
            tick();
        end

        // drain the whole list, then free p40 while empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 1, 32 + i, 32 - i, 0);
        step(1, 0, 0, 0, 0, 0, -1, 0, 0);
        step(1, 1, 40, 0, 0, 0, -1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 40, 1, 0);
        step(0, 0, 0, 0, 0, 0, -1, 0, 0);

        // steady alloc+free of p7 across pointer wrap
        do_reset();
        step(1, 0, 0, 0, 0, 1, 32, 32, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 7, 0, 0, 1, (i < 31) ? 33 + i : 7, 31, 0);

        // checkpoint save / restore sequences
        do_reset();
`ifdef FREE_LIST_CKPT_EN
        step(1, 0, 0, 0, 0, 1, 32, 32, 0);
        step(1, 0, 0, 1, 0, 1, 33, 31, 0);
        step(1, 0, 0, 0, 0, 1, 34, 30, 1);
        step(1, 0, 0, 0, 0, 1, 35, 29, 1);
        step(1, 0, 0, 0, 0, 1, 36, 28, 1);
        step(1, 0, 0, 0, 1, 0, 37, 27, 1);
        step(0, 0, 0, 0, 0, 0, 34, 30, 0);
        step(0, 0, 0, 1, 0, 0, 34, 30, 0);
        step(1, 0, 0, 0, 0, 1, 34, 30, 1);
        step(1, 0, 0, 0, 0, 1, 35, 29, 1);
        step(1, 0, 0, 1, 1, 0, 36, 28, 1);
        step(0, 0, 0, 0, 0, 0, 34, 30, 0);
`else
        step(1, 0, 0, 0, 0, 1, 32, 32, 0);
        step(1, 0, 0, 1, 0, 1, 33, 31, 0);
        step(1, 0, 0, 0, 0, 1, 34, 30, 0);
        step(1, 0, 0, 0, 0, 1, 35, 29, 0);
        step(1, 0, 0, 0, 0, 1, 36, 28, 0);
        step(1, 0, 0, 0, 1, 1, 37, 27, 0);
        step(0, 0, 0, 0, 0, 0, 38, 26, 0);
        step(0, 0, 0, 1, 0, 0, 38, 26, 0);
        step(1, 0, 0, 0, 0, 1, 38, 26, 0);
        step(1, 0, 0, 0, 0, 1, 39, 25, 0);
        step(1, 0, 0, 1, 1, 1, 40, 24, 0);
        step(0, 0, 0, 0, 0, 0, 41, 23, 0);
`endif

        // randomized traffic against the queue model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit rq, fv, sv, rs, eg, drop, push;
            int pr, sz0;
            rq = ($urandom % 4) != 0;
            fv = ($urandom % 3) != 0;
            pr = (($urandom % 8) == 0) ? 0 : int'($urandom % 64);
            sv = ($urandom % 12) == 0;
            rs = !sv && (($urandom % 12) == 0);
            if ((c % 500) == 250) begin
                sv = 1'b1;
                rs = 1'b1;
            end
            if (CKPT && mv && fq.size() + since.size() >= DEPTH) fv = 1'b0;
            if (($urandom % 300) == 0) begin
                rst = 1'b1;
                drive(rq, fv, pr, sv, rs);
                tick();
                rst = 1'b0;
                model_reset();
                continue;
            end
            drive(rq, fv, pr, sv, rs);
            @(negedge clk);
            sz0 = fq.size();
            eg = rq && (sz0 > 0) && !(CKPT && rs);
            chk("rnd_gnt", int'(bus.alloc_gnt_o), int'(eg));
            if (sz0 > 0) chk("rnd_preg", int'(bus.alloc_preg_o), fq[0]);
            chk("rnd_count", int'(bus.count_o), sz0);
            chk("rnd_empty", int'(bus.empty_o), int'(sz0 == 0));
            chk("rnd_ovf", int'(bus.overflow_o), int'(movf));
            chk("rnd_cv", int'(bus.ckpt_valid_o), int'(mv));
            drop = fv && (pr != 0) && (sz0 >= DEPTH);
            push = fv && (pr != 0) && !drop;
            if (CKPT && rs) begin
                if (mv) begin
                    fq = {since, fq};
                    since = {};
                    mv = 1'b0;
                end
            end else begin
                if (eg) begin
                    int p;
                    p = fq.pop_front();
                    if (mv) since.push_back(p);
                end
                if (CKPT && sv) begin
                    mv = 1'b1;
                    since = {};
                end
            end
            if (push) fq.push_back(pr);
            movf = drop;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
